nla_seq: RTL and testbench
==========================

NLA_SEQ -- requirements
Module: nla_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, MAC operand and result width.
REQ-002 SHALL have parameter ADDR_LINES, default 5, coefficient address width (2^ADDR_LINES entries per bank).
REQ-003 SHALL have parameter WDOG_CYCLES, default 256, MAC result timeout in cycles.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  evaluation request
- req_ready_o  out  1  request accepted when high with req_valid_i
- x_i  in  DATA_WIDTH  input sample
- mode_i  in  1  0 = SeLu bank, 1 = TanH bank
- cfg_we_i  in  1  coefficient write strobe
- cfg_len_we_i  in  1  term-count write strobe
- cfg_bank_i  in  1  bank selected for writes
- cfg_addr_i  in  ADDR_LINES  coefficient index
- cfg_data_i  in  DATA_WIDTH  coefficient word, or term count in low ADDR_LINES+1 bits
- signal_o  out  DATA_WIDTH  MAC signal operand
- coeff_o  out  DATA_WIDTH  MAC coefficient operand
- mac_valid_o  out  1  operand pair valid this cycle
- mode_o  out  1  MAC mode select
- full_mul_i  in  1  MAC multiplier FIFO full, stall
- mac_done_i  in  1  MAC result valid pulse
- mac_result_i  in  DATA_WIDTH  MAC result
- res_valid_o  out  1  one-cycle result pulse
- res_o  out  DATA_WIDTH  result, held until next res_valid_o
- busy_o  out  1  high outside IDLE
- err_o  out  1  one-cycle timeout pulse

Function
REQ-005 SHALL hold two banks of 2^ADDR_LINES coefficient registers plus one term-count register per bank.
REQ-006 SHALL write cfg_data_i to bank[cfg_bank_i][cfg_addr_i] on cfg_we_i, and term count on cfg_len_we_i, only in IDLE; writes in other states ignored.
REQ-007 SHALL clamp stored term count to 2^ADDR_LINES.
REQ-008 SHALL implement FSM IDLE -> ISSUE -> TERM -> WAIT -> DONE -> IDLE.
REQ-009 IDLE: req_ready_o = 1; on req_valid_i latch x_i and mode_i, set index = len-1, go ISSUE (len = 0 goes directly TERM).
REQ-010 ISSUE: each cycle with full_mul_i = 0 drive signal_o = x, coeff_o = bank[mode][index], mac_valid_o = 1, decrement index; after index 0 go TERM.
REQ-011 TERM: with full_mul_i = 0 drive signal_o = coeff_o = 32'h7F900000 (NaN marker), mac_valid_o = 1, go WAIT.
REQ-012 Stall: full_mul_i = 1 in ISSUE/TERM forces mac_valid_o = 0 that cycle; index and state hold.
REQ-013 mode_o SHALL equal the latched mode in all non-IDLE states.
REQ-014 WAIT: on mac_done_i capture mac_result_i into res_o, go DONE; mac_done_i outside WAIT ignored.
REQ-015 DONE: res_valid_o = 1 for exactly one cycle, then IDLE; request-to-first-operand latency 1 cycle.
REQ-016 req_ready_o = 0 outside IDLE; req_valid_i there ignored, not queued.

Reset
REQ-017 On rst_i, at any state including mid-evaluation: state IDLE, index 0, req_ready_o 1 after release, mac_valid_o 0, res_valid_o 0, err_o 0, busy_o 0, res_o 0, mode_o 0, signal_o/coeff_o 0.
REQ-018 Reset SHALL clear term counts to 0; coefficient registers not reset.

Configuration
REQ-019 Macro NLA_SEQ_WDOG_EN defined: WAIT counts cycles; at WDOG_CYCLES without mac_done_i set res_o = 32'h7FC00000, pulse err_o, go DONE.
REQ-020 Macro NLA_SEQ_WDOG_EN undefined: no counter; WAIT holds indefinitely; err_o tied 0.

Verification
REQ-021 Bank 0 len 10 loaded with SeLu coefficients, req x = 32'hBDFCD6E9 -> 10 pairs coeff index 9..0, then NaN pair, mac_valid_o high 11 consecutive cycles.
REQ-022 full_mul_i high 3 cycles during 4th issue -> mac_valid_o low exactly 3 cycles, same pair issued after, no term lost.
REQ-023 mac_done_i with 32'h3F800000 in WAIT -> res_o = 32'h3F800000, res_valid_o single pulse, return to IDLE next cycle.
REQ-024 len 0 request -> only NaN pair issued; cfg_we_i during ISSUE -> bank contents unchanged.
REQ-025 rst_i asserted mid-ISSUE -> next cycle all outputs at reset values, later request runs normally.
REQ-026 With NLA_SEQ_WDOG_EN, no mac_done_i -> err_o pulse and res_o = 32'h7FC00000 exactly WDOG_CYCLES after WAIT entry.

Source files
------------

// File: rtl/nla_seq.sv
// Non-linear-approximation sequencer: streams x/coefficient pairs into an external MAC, then a NaN terminator, and returns the MAC result.
// Optional macro NLA_SEQ_WDOG_EN enables a WAIT-state watchdog that forces a timeout result and err_o pulse.
module nla_seq #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_LINES  = 5,
    parameter int unsigned WDOG_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] x_i,
    input  logic                  mode_i,
    input  logic                  cfg_we_i,
    input  logic                  cfg_len_we_i,
    input  logic                  cfg_bank_i,
    input  logic [ADDR_LINES-1:0] cfg_addr_i,
    input  logic [DATA_WIDTH-1:0] cfg_data_i,
    output logic [DATA_WIDTH-1:0] signal_o,
    output logic [DATA_WIDTH-1:0] coeff_o,
    output logic                  mac_valid_o,
    output logic                  mode_o,
    input  logic                  full_mul_i,
    input  logic                  mac_done_i,
    input  logic [DATA_WIDTH-1:0] mac_result_i,
    output logic                  res_valid_o,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  busy_o,
    output logic                  err_o
);
    localparam int unsigned DEPTH = 1 << ADDR_LINES;
    localparam logic [ADDR_LINES:0]   LEN_MAX  = (ADDR_LINES + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NAN_MARK = DATA_WIDTH'(32'h7F90_0000);
    localparam logic [DATA_WIDTH-1:0] TMO_RES  = DATA_WIDTH'(32'h7FC0_0000);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_TERM,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] coef_mem [2][DEPTH];
    logic [ADDR_LINES:0]   len_q [2];
    logic [ADDR_LINES-1:0] index_q;
    logic [DATA_WIDTH-1:0] x_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  mode_q;

    logic                  in_idle;
    logic                  timeout;
    logic [ADDR_LINES:0]   len_req;
    logic [ADDR_LINES:0]   len_wr;

    assign in_idle = (state_q == ST_IDLE);
    assign len_req = len_q[mode_i];
    assign len_wr  = (cfg_data_i[ADDR_LINES:0] > LEN_MAX) ? LEN_MAX : cfg_data_i[ADDR_LINES:0];

`ifdef NLA_SEQ_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    assign timeout = (state_q == ST_WAIT) && !mac_done_i && (wdog_q == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != ST_WAIT) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 1'b1;
        end
        err_q <= rst_i ? 1'b0 : timeout;
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (req_valid_i) state_d = (len_req == '0) ? ST_TERM : ST_ISSUE;
            ST_ISSUE: if (!full_mul_i && index_q == '0) state_d = ST_TERM;
            ST_TERM:  if (!full_mul_i) state_d = ST_WAIT;
            ST_WAIT:  if (mac_done_i || timeout) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        signal_o    = '0;
        coeff_o     = '0;
        mac_valid_o = 1'b0;
        unique case (state_q)
            ST_ISSUE: begin
                signal_o    = x_q;
                coeff_o     = coef_mem[mode_q][index_q];
                mac_valid_o = !full_mul_i;
            end
            ST_TERM: begin
                signal_o    = NAN_MARK;
                coeff_o     = NAN_MARK;
                mac_valid_o = !full_mul_i;
            end
            default: ;
        endcase
    end

    assign req_ready_o = in_idle;
    assign busy_o      = !in_idle;
    assign res_valid_o = (state_q == ST_DONE);
    assign mode_o      = in_idle ? 1'b0 : mode_q;
    assign res_o       = res_q;

    // Terms issue from the highest index down; a zero-length bank skips straight to the terminator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q  <= '0;
            x_q      <= '0;
            mode_q   <= 1'b0;
            res_q    <= '0;
            len_q[0] <= '0;
            len_q[1] <= '0;
        end else begin
            if (in_idle && cfg_len_we_i) begin
                len_q[cfg_bank_i] <= len_wr;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        x_q     <= x_i;
                        mode_q  <= mode_i;
                        index_q <= (len_req == '0) ? '0 : ADDR_LINES'(len_req - 1'b1);
                    end
                end
                ST_ISSUE: begin
                    if (!full_mul_i && index_q != '0) begin
                        index_q <= index_q - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mac_done_i) begin
                        res_q <= mac_result_i;
                    end else if (timeout) begin
                        res_q <= TMO_RES;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_idle && cfg_we_i) begin
            coef_mem[cfg_bank_i][cfg_addr_i] <= cfg_data_i;
        end
    end

endmodule

// File: tb/tb_nla_seq.sv
// Randomized self-checking bench for nla_seq against a queue-based model of the operand stream and result handshake.
module tb_nla_seq;
    localparam int DW = 32;
    localparam int AL = 5;
    localparam int WD = 256;
    localparam int DEPTH = 1 << AL;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [DW-1:0] x_i;
    logic          mode_i;
    logic          cfg_we_i;
    logic          cfg_len_we_i;
    logic          cfg_bank_i;
    logic [AL-1:0] cfg_addr_i;
    logic [DW-1:0] cfg_data_i;
    logic [DW-1:0] signal_o;
    logic [DW-1:0] coeff_o;
    logic          mac_valid_o;
    logic          mode_o;
    logic          full_mul_i;
    logic          mac_done_i;
    logic [DW-1:0] mac_result_i;
    logic          res_valid_o;
    logic [DW-1:0] res_o;
    logic          busy_o;
    logic          err_o;

    nla_seq #(.DATA_WIDTH(DW), .ADDR_LINES(AL), .WDOG_CYCLES(WD)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .x_i(x_i), .mode_i(mode_i), .cfg_we_i(cfg_we_i), .cfg_len_we_i(cfg_len_we_i),
        .cfg_bank_i(cfg_bank_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
        .signal_o(signal_o), .coeff_o(coeff_o), .mac_valid_o(mac_valid_o), .mode_o(mode_o),
        .full_mul_i(full_mul_i), .mac_done_i(mac_done_i), .mac_result_i(mac_result_i),
        .res_valid_o(res_valid_o), .res_o(res_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_mem [2][DEPTH];
    int          mdl_len [2];
    logic [31:0] selu_coef [10] = '{32'h3F86_8D1F, 32'h3FD7_9A8C, 32'h3F11_2A44, 32'hBE8C_4E21,
                                    32'h3E12_F0A1, 32'hBD4C_8810, 32'h3C90_2B7E, 32'hBBC1_0F33,
                                    32'h3A7E_5512, 32'hB90A_C2E4};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_coef(input bit b, input int a, input logic [31:0] d);
        cfg_we_i = 1'b1; cfg_bank_i = b; cfg_addr_i = AL'(a); cfg_data_i = d;
        tick();
        cfg_we_i = 1'b0;
        mdl_mem[b][a] = d;
    endtask

    task automatic cfg_len(input bit b, input int unsigned v);
        int unsigned low;
        cfg_len_we_i = 1'b1; cfg_bank_i = b; cfg_data_i = v;
        tick();
        cfg_len_we_i = 1'b0;
        low = v % (2 * DEPTH);
        mdl_len[b] = (low > DEPTH) ? DEPTH : int'(low);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready_o, 1);
        check({tag, "_mac_valid"}, mac_valid_o, 0);
        check({tag, "_res_valid"}, res_valid_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_res"}, res_o, 0);
        check({tag, "_mode"}, mode_o, 0);
        check({tag, "_signal"}, signal_o, 0);
        check({tag, "_coeff"}, coeff_o, 0);
    endtask

    task automatic start_req(input bit m, input logic [31:0] x);
        req_valid_i = 1'b1; x_i = x; mode_i = m;
        @(negedge clk_i);
        check("req_ready_idle", req_ready_o, 1);
        check("busy_idle", busy_o, 0);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic clear_noise();
        req_valid_i = 1'b0; cfg_we_i = 1'b0; cfg_len_we_i = 1'b0;
        mac_done_i = 1'b0; full_mul_i = 1'b0;
    endtask

    // stall_mode: 0 none, 1 three-cycle stall on the 4th issue, 2 random stalls plus ignored side-traffic
    task automatic run_txn(input bit m, input logic [31:0] x, input int stall_mode,
                           input logic [31:0] result, input bit long_wait);
        logic [31:0] q_sig [$];
        logic [31:0] q_coef [$];
        for (int i = mdl_len[m] - 1; i >= 0; i--) begin
            q_sig.push_back(x);
            q_coef.push_back(mdl_mem[m][i]);
        end
        q_sig.push_back(32'h7F90_0000);
        q_coef.push_back(32'h7F90_0000);

        start_req(m, x);
        for (int it = 0; it < 400 && q_sig.size() > 0; it++) begin
            case (stall_mode)
                0: full_mul_i = 1'b0;
                1: full_mul_i = (it >= 3 && it <= 5);
                default: begin
                    full_mul_i   = ($urandom_range(0, 3) == 0);
                    req_valid_i  = 1'($urandom_range(0, 1));
                    x_i          = $urandom;
                    mode_i       = 1'($urandom_range(0, 1));
                    cfg_we_i     = 1'($urandom_range(0, 1));
                    cfg_len_we_i = 1'($urandom_range(0, 1));
                    cfg_bank_i   = 1'($urandom_range(0, 1));
                    cfg_addr_i   = AL'($urandom_range(0, DEPTH - 1));
                    cfg_data_i   = $urandom;
                    mac_done_i   = 1'($urandom_range(0, 1));
                    mac_result_i = $urandom;
                end
            endcase
            @(negedge clk_i);
            check("mac_valid", mac_valid_o, !full_mul_i);
            check("mode_o", mode_o, m);
            check("ready_busy", req_ready_o, 0);
            if (mac_valid_o) begin
                check("signal", signal_o, q_sig.pop_front());
                check("coeff", coeff_o, q_coef.pop_front());
            end
            tick();
        end
        check("issue_left", q_sig.size(), 0);
        clear_noise();

        if (long_wait) begin
`ifdef NLA_SEQ_WDOG_EN
            for (int k = 0; k < WD; k++) begin
                @(negedge clk_i);
                check("wdog_early_err", err_o, 0);
                check("wdog_early_done", res_valid_o, 0);
                tick();
            end
            @(negedge clk_i);
            check("wdog_err", err_o, 1);
            check("wdog_res_valid", res_valid_o, 1);
            check("wdog_res", res_o, 32'h7FC0_0000);
            tick();
            @(negedge clk_i);
            check("wdog_err_pulse", err_o, 0);
            check("wdog_idle", req_ready_o, 1);
            tick();
            return;
`else
            repeat (WD + 44) begin
                @(negedge clk_i);
                check("hold_err", err_o, 0);
                check("hold_busy", busy_o, 1);
                check("hold_res_valid", res_valid_o, 0);
                tick();
            end
`endif
        end else begin
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk_i);
                check("wait_mac_valid", mac_valid_o, 0);
                check("wait_busy", busy_o, 1);
                check("wait_res_valid", res_valid_o, 0);
                tick();
            end
        end

        mac_done_i = 1'b1; mac_result_i = result;
        @(negedge clk_i);
        check("res_valid_in_wait", res_valid_o, 0);
        tick();
        mac_done_i = 1'b0; mac_result_i = $urandom;
        @(negedge clk_i);
        check("res_valid", res_valid_o, 1);
        check("res", res_o, result);
        check("err_done", err_o, 0);
        check("ready_done", req_ready_o, 0);
        tick();
        @(negedge clk_i);
        check("res_valid_pulse", res_valid_o, 0);
        check("ready_after", req_ready_o, 1);
        check("busy_after", busy_o, 0);
        check("res_held", res_o, result);
        check("mode_idle", mode_o, 0);
        tick();
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL global_timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] xr;
        rst_i = 1'b1; x_i = '0; mode_i = 1'b0; cfg_bank_i = 1'b0; cfg_addr_i = '0;
        cfg_data_i = '0; mac_result_i = '0;
        clear_noise();
        mdl_len[0] = 0; mdl_len[1] = 0;
        tick(); tick();
        @(negedge clk_i);
        check_reset_outputs("por");
        tick();
        rst_i = 1'b0;

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                cfg_coef(1'(b), a, $urandom);
        for (int i = 0; i < 10; i++) cfg_coef(1'b0, i, selu_coef[i]);

        cfg_len(1'b0, 10);
        run_txn(1'b0, 32'hBDFC_D6E9, 0, 32'h3F80_0000, 1'b0);
        run_txn(1'b0, $urandom, 1, $urandom, 1'b0);
        cfg_len(1'b1, 40);
        run_txn(1'b1, $urandom, 2, $urandom, 1'b0);
        cfg_len(1'b0, 0);
        run_txn(1'b0, $urandom, 2, $urandom, 1'b0);

        repeat (8) begin
            cfg_len(1'($urandom_range(0, 1)), $urandom_range(0, 63));
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 1) * 2, $urandom, 1'b0);
        end

        cfg_len(1'b1, 20);
        xr = $urandom;
        start_req(1'b1, xr);
        repeat (3) begin
            @(negedge clk_i);
            check("pre_rst_valid", mac_valid_o, 1);
            check("pre_rst_signal", signal_o, xr);
            tick();
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("mid_rst");
        tick();
        mdl_len[0] = 0; mdl_len[1] = 0;

        run_txn(1'b1, $urandom, 0, $urandom, 1'b0);
        cfg_len(1'b0, 5);
        run_txn(1'b0, $urandom, 2, $urandom, 1'b0);
        run_txn(1'b0, $urandom, 0, $urandom, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
